axis_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one AXI-Stream output among NS AXI-Stream requesters. It sits in front of a single downstream stream consumer (register slice, FIFO, or sink) where several producers contend for it. A grant is held from the first beat to the tlast beat of a packet, so packets are never interleaved. The output is registered for full throughput within a packet.

---
 rtl/axis_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_axis_rr_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: NS AXI-Stream requesters share one registered
// AXI-Stream output, and a grant is held from the first beat through the tlast beat.
module axis_rr_arbiter #(
    parameter int DW = 8,
    parameter int NS = 4,
    localparam int IW = $clog2(NS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NS*DW-1:0] s_tdata,
    input  logic [NS-1:0]    s_tvalid,
    input  logic [NS-1:0]    s_tlast,
    output logic [NS-1:0]    s_tready,
    output logic [DW-1:0]    m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic [IW-1:0]    grant_id,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE,
        PASS
    } state_t;

    state_t          state_q,    state_d;
    logic [IW-1:0]   ptr_q,      ptr_d;
    logic [IW-1:0]   grant_q,    grant_d;
    logic [DW-1:0]   m_tdata_q,  m_tdata_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic            m_tlast_q,  m_tlast_d;

    logic [DW-1:0]   data_arr [NS];
    logic [IW-1:0]   sel;
    logic [IW-1:0]   cand;
    logic            any_req;
    logic            out_ready;
    logic            accept;

    for (genvar gi = 0; gi < NS; gi++) begin : g_unpack
        assign data_arr[gi] = s_tdata[gi*DW +: DW];
    end

    // Search upward from ptr+1 so the last grantee is considered last.
    always_comb begin
        sel     = ptr_q;
        cand    = '0;
        any_req = 1'b0;
        for (int k = 1; k <= NS; k++) begin
            cand = IW'((int'(ptr_q) + k) % NS);
            if (!any_req && s_tvalid[cand]) begin
                sel     = cand;
                any_req = 1'b1;
            end
        end
    end

    assign out_ready = !m_tvalid_q || m_tready;
    assign accept    = (state_q == PASS) && s_tvalid[grant_q] && out_ready;

    always_comb begin
        s_tready = '0;
        if (state_q == PASS) begin
            s_tready[grant_q] = out_ready;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;

        // A consumed output beat empties the register unless refilled this cycle.
        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = sel;
                    ptr_d   = sel;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (accept) begin
                    m_tdata_d  = data_arr[grant_q];
                    m_tlast_d  = s_tlast[grant_q];
                    m_tvalid_d = 1'b1;
                    if (s_tlast[grant_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(NS - 1);
            grant_q    <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == PASS);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter: per-requester packet queues feed
// the inputs and accepted output beats are logged with their cycle numbers.
module tb_axis_rr_arbiter;

    localparam int DW = 8;
    localparam int NS = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS*DW-1:0] s_tdata;
    logic [NS-1:0]    s_tvalid;
    logic [NS-1:0]    s_tlast;
    logic [NS-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready;
    logic [IW-1:0]    grant_id;
    logic             busy;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } beat_t;

    beat_t      src_q [NS][$];
    logic [7:0] out_data [$];
    logic       out_last [$];
    int         out_cyc [$];
    int         pop_cnt [NS];
    int         cyc;
    int         checks;
    int         errors;

    axis_rr_arbiter #(.DW(DW), .NS(NS)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are sampled at the negedge; queue fronts are re-presented 1ns after each posedge.
    initial begin : driver
        logic [NS-1:0] fire;
        beat_t         b;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        forever begin
            @(negedge clk);
            fire = s_tvalid & s_tready;
            if (!rst && m_tvalid && m_tready) begin
                out_data.push_back(m_tdata);
                out_last.push_back(m_tlast);
                out_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (fire[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    pop_cnt[i]++;
                end
                s_tvalid[i]         = 1'b0;
                s_tlast[i]          = 1'b0;
                s_tdata[i*DW +: DW] = '0;
                if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    if (b.gap > 0) begin
                        b.gap--;
                        src_q[i][0] = b;
                    end else begin
                        s_tvalid[i]         = 1'b1;
                        s_tlast[i]          = b.last;
                        s_tdata[i*DW +: DW] = b.data;
                    end
                end
            end
        end
    end

    task automatic push_pkt(input int req, input logic [7:0] first, input int n,
                            input int gap_at, input int gap_len);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = first + 8'(k);
            b.last = (k == n - 1);
            b.gap  = (k == gap_at) ? gap_len : 0;
            src_q[req].push_back(b);
        end
    endtask

    task automatic clear_log();
        out_data.delete();
        out_last.delete();
        out_cyc.delete();
    endtask

    task automatic wait_out(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk);
            #2;
            if (out_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
        checks++;
        if (m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_tlast: got %b expected 0", m_tlast); end
        checks++;
        if (m_tdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_m_tdata: got %h expected 00", m_tdata); end
        checks++;
        if (s_tready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_s_tready: got %b expected 0000", s_tready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grant_id); end
    endtask

    task automatic test_first_grant();
        logic [7:0] exp_d [8] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1};
        int  c0;
        bit  ok;
        logic [7:0] got;
        rst = 1'b0;
        clear_log();
        c0 = cyc;
        push_pkt(0, 8'hA0, 2, -1, 0);
        push_pkt(1, 8'hB0, 2, -1, 0);
        push_pkt(2, 8'hC0, 2, -1, 0);
        push_pkt(3, 8'hD0, 2, -1, 0);
        wait_out(8, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL first_grant_timeout: got %0d beats expected 8", out_data.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < out_data.size()) ? out_data[i] : 8'hxx;
            checks++;
            if (got !== exp_d[i]) begin errors++; $display("[TB] FAIL first_grant_data[%0d]: got %h expected %h", i, got, exp_d[i]); end
            checks++;
            if (i < out_last.size() && out_last[i] !== (i % 2 == 1)) begin
                errors++; $display("[TB] FAIL first_grant_last[%0d]: got %b expected %b", i, out_last[i], (i % 2 == 1));
            end
        end
        checks++;
        if (out_cyc.size() > 0 && out_cyc[0] !== c0 + 3) begin
            errors++; $display("[TB] FAIL first_beat_latency: got cycle %0d expected %0d", out_cyc[0], c0 + 3);
        end
        for (int i = 1; i < 8 && i < out_cyc.size(); i++) begin
            checks++;
            if (out_cyc[i] - out_cyc[i-1] !== ((i % 2 == 0) ? 2 : 1)) begin
                errors++; $display("[TB] FAIL first_grant_spacing[%0d]: got %0d expected %0d", i, out_cyc[i] - out_cyc[i-1], (i % 2 == 0) ? 2 : 1);
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        clear_log();
        push_pkt(2, 8'hC5, 1, -1, 0);
        wait_out(1, 20, ok);
        clear_log();
        push_pkt(0, 8'hA5, 1, -1, 0);
        push_pkt(3, 8'hD5, 1, -1, 0);
        wait_out(2, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL rr_wrap_timeout: got %0d beats expected 2", out_data.size()); end
        checks++;
        if (out_data[0] !== 8'hD5) begin errors++; $display("[TB] FAIL rr_wrap_first: got %h expected D5", out_data[0]); end
        checks++;
        if (out_data[1] !== 8'hA5) begin errors++; $display("[TB] FAIL rr_wrap_second: got %h expected A5", out_data[1]); end
        clear_log();
        push_pkt(0, 8'hA6, 1, -1, 0);
        push_pkt(1, 8'hB6, 1, -1, 0);
        wait_out(2, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL rr_ptr_timeout: got %0d beats expected 2", out_data.size()); end
        checks++;
        if (out_data[0] !== 8'hB6) begin errors++; $display("[TB] FAIL rr_ptr_first: got %h expected B6", out_data[0]); end
        checks++;
        if (out_data[1] !== 8'hA6) begin errors++; $display("[TB] FAIL rr_ptr_second: got %h expected A6", out_data[1]); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
        bit found;
        bit ok;
        clear_log();
        push_pkt(1, 8'h10, 4, -1, 0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (m_tvalid && m_tdata == 8'h11) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL bp_beat2_timeout: got m_tdata %h expected 11", m_tdata); end
        m_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (m_tdata !== 8'h11 || m_tvalid !== 1'b1) begin
                errors++; $display("[TB] FAIL bp_hold[%0d]: got %h/%b expected 11/1", k, m_tdata, m_tvalid);
            end
            checks++;
            if (s_tready[1] !== 1'b0) begin errors++; $display("[TB] FAIL bp_s_tready[%0d]: got %b expected 0", k, s_tready[1]); end
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        wait_out(4, 20, ok);
        repeat (3) @(posedge clk);
        checks++;
        if (out_data.size() !== 4) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 4", out_data.size()); end
        for (int i = 0; i < 4 && i < out_data.size(); i++) begin
            checks++;
            if (out_data[i] !== exp_d[i] || out_last[i] !== (i == 3)) begin
                errors++; $display("[TB] FAIL bp_beat[%0d]: got %h/%b expected %h/%b", i, out_data[i], out_last[i], exp_d[i], (i == 3));
            end
        end
    endtask

    task automatic test_valid_gap();
        logic [7:0] exp_d [5] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h50};
        int  base;
        int  busy_seen;
        bit  ok;
        clear_log();
        base      = pop_cnt[0];
        busy_seen = 0;
        push_pkt(0, 8'h40, 4, 1, 2);
        push_pkt(1, 8'h50, 1, -1, 0);
        for (int k = 0; k < 30 && pop_cnt[0] - base < 4; k++) begin
            @(negedge clk);
            if (busy && pop_cnt[0] - base < 4) begin
                busy_seen++;
                checks++;
                if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL gap_grant_id: got %0d expected 0", grant_id); end
                checks++;
                if (s_tready[1] !== 1'b0) begin errors++; $display("[TB] FAIL gap_s_tready1: got %b expected 0", s_tready[1]); end
            end
        end
        checks++;
        if (busy_seen < 6) begin errors++; $display("[TB] FAIL gap_pass_cycles: got %0d expected >= 6", busy_seen); end
        wait_out(5, 30, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL gap_timeout: got %0d beats expected 5", out_data.size()); end
        for (int i = 0; i < 5 && i < out_data.size(); i++) begin
            checks++;
            if (out_data[i] !== exp_d[i]) begin errors++; $display("[TB] FAIL gap_data[%0d]: got %h expected %h", i, out_data[i], exp_d[i]); end
        end
    endtask

    task automatic test_single_beat();
        logic [7:0] exp_d [6] = '{8'h60, 8'h70, 8'h61, 8'h71, 8'h62, 8'h72};
        bit ok;
        clear_log();
        for (int k = 0; k < 3; k++) begin
            push_pkt(0, 8'h60 + 8'(k), 1, -1, 0);
            push_pkt(1, 8'h70 + 8'(k), 1, -1, 0);
        end
        wait_out(6, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL single_timeout: got %0d beats expected 6", out_data.size()); end
        for (int i = 0; i < 6 && i < out_data.size(); i++) begin
            checks++;
            if (out_data[i] !== exp_d[i] || out_last[i] !== 1'b1) begin
                errors++; $display("[TB] FAIL single_beat[%0d]: got %h/%b expected %h/1", i, out_data[i], out_last[i], exp_d[i]);
            end
            if (i > 0) begin
                checks++;
                if (out_cyc[i] - out_cyc[i-1] !== 2) begin
                    errors++; $display("[TB] FAIL single_spacing[%0d]: got %0d expected 2", i, out_cyc[i] - out_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        bit ok;
        clear_log();
        push_pkt(2, 8'h80, 5, -1, 0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (m_tvalid && m_tdata == 8'h81) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL arst_beat2_timeout: got m_tdata %h expected 81", m_tdata); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL arst_m_tvalid: got %b expected 0", m_tvalid); end
        checks++;
        if (s_tready !== 4'b0000) begin errors++; $display("[TB] FAIL arst_s_tready: got %b expected 0000", s_tready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL arst_busy: got %b expected 0", busy); end
        checks++;
        if (m_tdata !== 8'h00) begin errors++; $display("[TB] FAIL arst_m_tdata: got %h expected 00", m_tdata); end
        for (int i = 0; i < NS; i++) src_q[i].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        push_pkt(3, 8'h93, 1, -1, 0);
        push_pkt(1, 8'h91, 1, -1, 0);
        wait_out(2, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL arst_restart_timeout: got %0d beats expected 2", out_data.size()); end
        checks++;
        if (out_data[0] !== 8'h91) begin errors++; $display("[TB] FAIL arst_first_grant: got %h expected 91", out_data[0]); end
        checks++;
        if (out_data[1] !== 8'h93) begin errors++; $display("[TB] FAIL arst_second_grant: got %h expected 93", out_data[1]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first_grant();
        test_round_robin();
        test_backpressure();
        test_valid_gap();
        test_single_beat();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
